// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan controller: FSM state encoding, mode values
// and the channel count of the downstream 3-to-8 decoder.
package scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } scan_state_t;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    localparam int NCH = 8;

endpackage : scan_ctrl_pkg

// File: rtl/scan_ctrl_next_chan.sv
// Channel lookup: the lowest enabled channel, and the next enabled channel
// strictly above the current one, wrapping to the lowest when none exists.
module next_chan
    import scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [2:0]     cur,
    output logic [2:0]     nxt,
    output logic           wrap,
    output logic [2:0]     first,
    output logic           any
);

    logic [2:0] nxtAbove;
    logic       foundAbove;

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        first      = 3'd0;
        nxtAbove   = 3'd0;
        foundAbove = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = 3'(i);
                if (3'(i) > cur) begin
                    nxtAbove   = 3'(i);
                    foundAbove = 1'b1;
                end
            end
        end
    end

    assign wrap = ~foundAbove;
    assign nxt  = foundAbove ? nxtAbove : first;
    assign any  = |mask;

endmodule : next_chan

// File: rtl/scan_ctrl.sv
// Decoder scan sequencer: walks the enabled channels of a mask, holding each
// for dwell+1 cycles with a one-cycle blank between channels.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    scan_state_t        state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               mode_q, mode_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [7:0] lookupMask;
    logic [2:0] ncNxt;
    logic [2:0] ncFirst;
    logic       ncWrap;
    logic       ncAny;

    // One lookup serves both the start-time first channel and the BLANK advance.
    assign lookupMask = (state_q == ST_IDLE) ? mask : mask_q;

    next_chan u_next_chan (
        .mask  (lookupMask),
        .cur   (sel_q),
        .nxt   (ncNxt),
        .wrap  (ncWrap),
        .first (ncFirst),
        .any   (ncAny)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_CONT;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ncAny) begin
                        mask_d  = mask;
                        mode_d  = mode;
                        dwell_d = dwell;
                        cnt_d   = dwell;
                        sel_d   = ncFirst;
                        state_d = ST_ACTIVE;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_BLANK;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                    en_d  = 1'b1;
                end
            end
            ST_BLANK: begin
                if (ncWrap && (mode_q == MODE_SINGLE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    sel_d   = ncNxt;
                    cnt_d   = dwell_q;
                    state_d = ST_ACTIVE;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything above, including a same-cycle start.
        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            dwell_d = dwell_q;
            mask_d  = mask_q;
            mode_d  = mode_q;
            sel_d   = sel_q;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : scan_ctrl
